// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage. It keeps up to MAX_OUTSTANDING bus requests in
// flight and buffers the returned instructions, plus AdEL exceptions, in an
// in-order result queue that feeds ID.
module fetch_queue_stage #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned QUEUE_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        resetn,
    // instruction bus
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    // PC generator side
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    output logic        ready_o,
    // ID side
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        exc_o,
    output logic [4:0]  exccode_o,
    output logic [31:0] badvaddr_o,
    input  logic        ready_i,
    input  logic        cancel_i,
    output logic        wait_data
);

    localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned QW  = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned SW  = QW + 1;
    localparam int unsigned PPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned QPW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam logic [4:0]  EXC_ADEL = 5'h04;

    // Pending FIFO: PCs of accepted requests awaiting their response
    logic [31:0]    pend_pc_q [MAX_OUTSTANDING];
    logic [PPW-1:0] pend_rptr_q, pend_rptr_d;
    logic [PPW-1:0] pend_wptr_q, pend_wptr_d;
    logic [OW-1:0]  outstanding_q, outstanding_d;
    logic [OW-1:0]  discard_q, discard_d;

    // Result queue
    logic [31:0]    q_pc_q   [QUEUE_DEPTH];
    logic [31:0]    q_inst_q [QUEUE_DEPTH];
    logic           q_exc_q  [QUEUE_DEPTH];
    logic [QPW-1:0] q_rptr_q, q_rptr_d;
    logic [QPW-1:0] q_wptr_q, q_wptr_d;
    logic [QW-1:0]  qcount_q, qcount_d;

    logic           adel_c;
    logic           credit_c;
    logic           slot_c;
    logic           issue_c;
    logic           exc_acc_c;
    logic           q_push_c;
    logic           q_pop_c;
    logic [31:0]    push_pc_c;
    logic [31:0]    push_inst_c;
    logic           push_exc_c;
    logic [SW-1:0]  inflight_sum_c;

    // Issue / accept decisions from current state
    always_comb begin
        adel_c         = |pc_i[1:0];
        inflight_sum_c = SW'(outstanding_q) + SW'(qcount_q);
        credit_c       = inflight_sum_c < SW'(QUEUE_DEPTH);
        slot_c         = outstanding_q < OW'(MAX_OUTSTANDING);
        inst_req       = resetn & valid_i & ~adel_c & ~cancel_i & credit_c & slot_c;
        issue_c        = inst_req & inst_addr_ok;
        exc_acc_c      = resetn & valid_i & adel_c & ~cancel_i & credit_c
                         & (outstanding_q == '0);
        ready_o        = issue_c | exc_acc_c;
        inst_addr      = pc_i;
    end

    // Queue push/pop selection; a pushed exception never coincides with a response
    always_comb begin
        q_pop_c     = valid_o & ready_i & ~cancel_i;
        q_push_c    = exc_acc_c | (inst_data_ok & (discard_q == '0) & ~cancel_i);
        push_pc_c   = pend_pc_q[pend_rptr_q];
        push_inst_c = inst_rdata;
        push_exc_c  = 1'b0;
        if (exc_acc_c) begin
            push_pc_c   = pc_i;
            push_inst_c = '0;
            push_exc_c  = 1'b1;
        end
    end

    // Next-state for counters and pointers
    always_comb begin
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        pend_rptr_d   = pend_rptr_q;
        pend_wptr_d   = pend_wptr_q;
        qcount_d      = qcount_q;
        q_rptr_d      = q_rptr_q;
        q_wptr_d      = q_wptr_q;

        if (issue_c && !inst_data_ok)      outstanding_d = outstanding_q + OW'(1);
        else if (!issue_c && inst_data_ok) outstanding_d = outstanding_q - OW'(1);

        if (issue_c)
            pend_wptr_d = (pend_wptr_q == PPW'(MAX_OUTSTANDING - 1)) ? '0 : pend_wptr_q + PPW'(1);
        if (inst_data_ok)
            pend_rptr_d = (pend_rptr_q == PPW'(MAX_OUTSTANDING - 1)) ? '0 : pend_rptr_q + PPW'(1);

        if (cancel_i) begin
            // everything still in flight except a response landing now gets dropped
            discard_d = outstanding_q - OW'(inst_data_ok);
            qcount_d  = '0;
            q_rptr_d  = '0;
            q_wptr_d  = '0;
        end else begin
            if (inst_data_ok && discard_q != '0) discard_d = discard_q - OW'(1);
            if (q_push_c && !q_pop_c)      qcount_d = qcount_q + QW'(1);
            else if (!q_push_c && q_pop_c) qcount_d = qcount_q - QW'(1);
            if (q_push_c)
                q_wptr_d = (q_wptr_q == QPW'(QUEUE_DEPTH - 1)) ? '0 : q_wptr_q + QPW'(1);
            if (q_pop_c)
                q_rptr_d = (q_rptr_q == QPW'(QUEUE_DEPTH - 1)) ? '0 : q_rptr_q + QPW'(1);
        end
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            outstanding_q <= '0;
            discard_q     <= '0;
            pend_rptr_q   <= '0;
            pend_wptr_q   <= '0;
            qcount_q      <= '0;
            q_rptr_q      <= '0;
            q_wptr_q      <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            pend_rptr_q   <= pend_rptr_d;
            pend_wptr_q   <= pend_wptr_d;
            qcount_q      <= qcount_d;
            q_rptr_q      <= q_rptr_d;
            q_wptr_q      <= q_wptr_d;
        end
    end

    // Storage arrays; contents are only observed through valid pointers
    always_ff @(posedge clk) begin
        if (issue_c) pend_pc_q[pend_wptr_q] <= pc_i;
        if (q_push_c) begin
            q_pc_q[q_wptr_q]   <= push_pc_c;
            q_inst_q[q_wptr_q] <= push_inst_c;
            q_exc_q[q_wptr_q]  <= push_exc_c;
        end
    end

    // Head-of-queue outputs, forced to zero while the queue is empty
    always_comb begin
        valid_o    = qcount_q != '0;
        wait_data  = outstanding_q != '0;
        pc_o       = valid_o ? q_pc_q[q_rptr_q] : '0;
        inst_o     = valid_o ? q_inst_q[q_rptr_q] : '0;
        exc_o      = valid_o & q_exc_q[q_rptr_q];
        exccode_o  = exc_o ? EXC_ADEL : 5'h00;
        badvaddr_o = exc_o ? q_pc_q[q_rptr_q] : '0;
    end

    // A response with nothing outstanding is a bus protocol violation
    assert property (@(posedge clk) disable iff (!resetn)
                     !(inst_data_ok && outstanding_q == '0));

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage: streaming, backpressure, AdEL
// ordering, cancel draining and reset.
module tb_fetch_queue_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        valid_i;
    logic [31:0] pc_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        exc_o;
    logic [4:0]  exccode_o;
    logic [31:0] badvaddr_o;
    logic        ready_i;
    logic        cancel_i;
    logic        wait_data;

    int errors = 0;
    int checks = 0;

    fetch_queue_stage #(.MAX_OUTSTANDING(2), .QUEUE_DEPTH(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .inst_rdata  (inst_rdata),
        .valid_i     (valid_i),
        .pc_i        (pc_i),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .pc_o        (pc_o),
        .inst_o      (inst_o),
        .exc_o       (exc_o),
        .exccode_o   (exccode_o),
        .badvaddr_o  (badvaddr_o),
        .ready_i     (ready_i),
        .cancel_i    (cancel_i),
        .wait_data   (wait_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance past the edge, then clear per-cycle bus strobes
    task automatic tick();
        @(posedge clk);
        #1;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        cancel_i     = 1'b0;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        resetn = 1'b0; valid_i = 1'b0; pc_i = 32'h0; ready_i = 1'b0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0; cancel_i = 1'b0;
        tick(); tick();

        // reset state
        settle();
        chk("rst_valid_o", valid_o, 1'b0);
        chk("rst_wait", wait_data, 1'b0);
        chk("rst_pc_o", pc_o, 32'h0);
        chk("rst_exc_o", exc_o, 1'b0);
        valid_i = 1'b1; pc_i = 32'h1000; inst_addr_ok = 1'b1; settle();
        chk("rst_req_gated", inst_req, 1'b0);
        chk("rst_ready_gated", ready_o, 1'b0);
        tick();
        resetn = 1'b1; valid_i = 1'b0;

        // 1. streaming
        ready_i = 1'b1;
        valid_i = 1'b1; pc_i = 32'h1000; inst_addr_ok = 1'b1; settle();
        chk("s_req0", inst_req, 1'b1);
        chk("s_addr0", inst_addr, 32'h1000);
        chk("s_ready0", ready_o, 1'b1);
        tick();
        pc_i = 32'h1004; inst_addr_ok = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hA0; settle();
        chk("s_ready1", ready_o, 1'b1);
        chk("s_valid_empty", valid_o, 1'b0);
        tick();
        pc_i = 32'h1008; inst_addr_ok = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hA1; settle();
        chk("s_pc0", pc_o, 32'h1000);
        chk("s_inst0", inst_o, 32'hA0);
        tick();
        pc_i = 32'h100C; inst_addr_ok = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hA2; settle();
        chk("s_pc1", pc_o, 32'h1004);
        chk("s_inst1", inst_o, 32'hA1);
        tick();
        valid_i = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hA3; settle();
        chk("s_pc2", pc_o, 32'h1008);
        chk("s_inst2", inst_o, 32'hA2);
        chk("s_wait", wait_data, 1'b1);
        tick();
        settle();
        chk("s_pc3", pc_o, 32'h100C);
        chk("s_inst3", inst_o, 32'hA3);
        tick();
        settle();
        chk("s_drained", valid_o, 1'b0);
        chk("s_wait_done", wait_data, 1'b0);

        // 2. backpressure
        ready_i = 1'b0;
        valid_i = 1'b1; pc_i = 32'h1100; inst_addr_ok = 1'b1; settle();
        chk("b_req0", inst_req, 1'b1);
        tick();
        pc_i = 32'h1104; inst_addr_ok = 1'b1; settle();
        chk("b_req1", inst_req, 1'b1);
        tick();
        pc_i = 32'h1108; inst_addr_ok = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hB0; settle();
        chk("b_req_outmax", inst_req, 1'b0);
        chk("b_ready_outmax", ready_o, 1'b0);
        tick();
        pc_i = 32'h1108; inst_addr_ok = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hB1; settle();
        chk("b_req2", inst_req, 1'b1);
        tick();
        pc_i = 32'h110C; inst_addr_ok = 1'b1; settle();
        chk("b_req3", inst_req, 1'b1);
        tick();
        pc_i = 32'h1110; inst_addr_ok = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hB2; settle();
        chk("b_req_full_a", inst_req, 1'b0);
        tick();
        pc_i = 32'h1110; inst_addr_ok = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hB3; settle();
        chk("b_req_full_b", inst_req, 1'b0);
        tick();
        pc_i = 32'h1110; inst_addr_ok = 1'b1; settle();
        chk("b_req_full_c", inst_req, 1'b0);
        chk("b_wait_zero", wait_data, 1'b0);
        chk("b_head_pc", pc_o, 32'h1100);
        chk("b_head_inst", inst_o, 32'hB0);
        ready_i = 1'b1; settle();
        chk("b_req_full_pop", inst_req, 1'b0);
        tick();
        valid_i = 1'b0; settle();
        chk("b_pc1", pc_o, 32'h1104);
        chk("b_inst1", inst_o, 32'hB1);
        tick();
        settle();
        chk("b_pc2", pc_o, 32'h1108);
        chk("b_inst2", inst_o, 32'hB2);
        tick();
        settle();
        chk("b_pc3", pc_o, 32'h110C);
        chk("b_inst3", inst_o, 32'hB3);
        tick();
        settle();
        chk("b_drained", valid_o, 1'b0);

        // 3. misaligned PC behind two outstanding requests
        valid_i = 1'b1; pc_i = 32'h1200; inst_addr_ok = 1'b1;
        tick();
        pc_i = 32'h1204; inst_addr_ok = 1'b1;
        tick();
        pc_i = 32'h2002; inst_addr_ok = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hC0; settle();
        chk("m_ready_out2", ready_o, 1'b0);
        chk("m_req_adel", inst_req, 1'b0);
        tick();
        pc_i = 32'h2002; inst_data_ok = 1'b1; inst_rdata = 32'hC1; settle();
        chk("m_ready_out1", ready_o, 1'b0);
        chk("m_pc0", pc_o, 32'h1200);
        chk("m_inst0", inst_o, 32'hC0);
        chk("m_exc0", exc_o, 1'b0);
        tick();
        pc_i = 32'h2002; settle();
        chk("m_ready_acc", ready_o, 1'b1);
        chk("m_req_acc", inst_req, 1'b0);
        chk("m_pc1", pc_o, 32'h1204);
        chk("m_inst1", inst_o, 32'hC1);
        tick();
        valid_i = 1'b0; settle();
        chk("m_valid", valid_o, 1'b1);
        chk("m_pc_exc", pc_o, 32'h2002);
        chk("m_exc", exc_o, 1'b1);
        chk("m_code", exccode_o, 5'h04);
        chk("m_badv", badvaddr_o, 32'h2002);
        chk("m_inst_zero", inst_o, 32'h0);
        tick();
        settle();
        chk("m_drained", valid_o, 1'b0);
        chk("m_code_idle", exccode_o, 5'h00);
        chk("m_badv_idle", badvaddr_o, 32'h0);

        // 4. cancel with two in flight and one queued
        ready_i = 1'b0;
        valid_i = 1'b1; pc_i = 32'h1300; inst_addr_ok = 1'b1;
        tick();
        pc_i = 32'h1304; inst_addr_ok = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hD0;
        tick();
        pc_i = 32'h1308; inst_addr_ok = 1'b1;
        tick();
        pc_i = 32'h1400; inst_addr_ok = 1'b1; cancel_i = 1'b1; ready_i = 1'b1; settle();
        chk("c_pre_valid", valid_o, 1'b1);
        chk("c_req_blocked", inst_req, 1'b0);
        chk("c_ready_blocked", ready_o, 1'b0);
        tick();
        pc_i = 32'h3000; inst_addr_ok = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hDEAD0001; settle();
        chk("c_valid_cleared", valid_o, 1'b0);
        chk("c_req_outmax", inst_req, 1'b0);
        tick();
        pc_i = 32'h3000; inst_addr_ok = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hDEAD0002; settle();
        chk("c_req_resume", inst_req, 1'b1);
        chk("c_drop1", valid_o, 1'b0);
        tick();
        valid_i = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hE0; settle();
        chk("c_drop2", valid_o, 1'b0);
        chk("c_wait", wait_data, 1'b1);
        tick();
        settle();
        chk("c_new_valid", valid_o, 1'b1);
        chk("c_new_pc", pc_o, 32'h3000);
        chk("c_new_inst", inst_o, 32'hE0);
        tick();
        settle();
        chk("c_drained", valid_o, 1'b0);

        // 5. cancel coinciding with a response
        valid_i = 1'b1; pc_i = 32'h1500; inst_addr_ok = 1'b1;
        tick();
        pc_i = 32'h1504; inst_addr_ok = 1'b1;
        tick();
        valid_i = 1'b0; cancel_i = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hF0;
        tick();
        valid_i = 1'b1; pc_i = 32'h1600; inst_addr_ok = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'hF1; settle();
        chk("x_valid_after_cancel", valid_o, 1'b0);
        chk("x_req_resume", inst_req, 1'b1);
        tick();
        valid_i = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hF2; settle();
        chk("x_one_dropped", valid_o, 1'b0);
        tick();
        settle();
        chk("x_valid", valid_o, 1'b1);
        chk("x_pc", pc_o, 32'h1600);
        chk("x_inst", inst_o, 32'hF2);
        tick();
        settle();
        chk("x_drained", valid_o, 1'b0);

        // 6. reset with three queued entries and one outstanding request
        ready_i = 1'b0;
        valid_i = 1'b1; pc_i = 32'h2006; settle();
        chk("r_exc_acc", ready_o, 1'b1);
        tick();
        tick();
        tick();
        pc_i = 32'h1700; inst_addr_ok = 1'b1; settle();
        chk("r_req_q3", inst_req, 1'b1);
        tick();
        valid_i = 1'b0; resetn = 1'b0; settle();
        chk("r_pre_valid", valid_o, 1'b1);
        chk("r_pre_wait", wait_data, 1'b1);
        chk("r_pre_exc", exc_o, 1'b1);
        tick();
        valid_i = 1'b1; pc_i = 32'h1800; settle();
        chk("r_valid", valid_o, 1'b0);
        chk("r_wait", wait_data, 1'b0);
        chk("r_req", inst_req, 1'b0);
        chk("r_pc_o", pc_o, 32'h0);
        tick();
        resetn = 1'b1; valid_i = 1'b1; pc_i = 32'h1800; settle();
        chk("r_req_after", inst_req, 1'b1);
        tick();
        valid_i = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
- Parametrised, pipelined instruction-fetch stage between the PC generator and ID.
- Keeps up to MAX_OUTSTANDING bus requests in flight and buffers returned instructions in a QUEUE_DEPTH-entry result queue, so ID stalls do not block fetch.
- Detects misaligned-PC (AdEL) exceptions in program order.
- Cancellation flushes buffered work and silently drains responses that are still in flight.

Parameters:
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered bus requests (>=1).
- QUEUE_DEPTH, 4, result-queue entries (>= MAX_OUTSTANDING).

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- inst_req  out  1  bus request valid.
- inst_addr  out  32  request address, equal to pc_i.
- inst_addr_ok  in  1  bus accepted the request this cycle.
- inst_data_ok  in  1  one in-order response this cycle.
- inst_rdata  in  32  response data.
- valid_i  in  1  pc_i valid.
- pc_i  in  32  fetch PC.
- ready_o  out  1  pc_i consumed this cycle.
- valid_o  out  1  queue head valid.
- pc_o  out  32  head PC.
- inst_o  out  32  head instruction (0 on exception).
- exc_o  out  1  head carries exception.
- exccode_o  out  5  EXC_ADEL when exc_o, else 0.
- badvaddr_o  out  32  head PC when exc_o, else 0.
- ready_i  in  1  ID accepts head.
- cancel_i  in  1  flush request.
- wait_data  out  1  outstanding count non-zero.

Behaviour:
State:
- pending FIFO of PCs, depth MAX_OUTSTANDING.
- outstanding counter, 0..MAX_OUTSTANDING.
- discard counter, 0..MAX_OUTSTANDING.
- result queue of {pc, inst, exc}, depth QUEUE_DEPTH, with qcount.
- Counter widths: $clog2(N+1).

Reset:
- All counters and pointers are 0.
- valid_o, exc_o, inst_req, ready_o and wait_data are 0.
- pc_o, inst_o, exccode_o and badvaddr_o are 0 while the queue is empty.

Issue and accept:
- adel = pc_i[1:0] != 0.
- credit = (outstanding + qcount) < QUEUE_DEPTH.
- inst_req = valid_i & !adel & !cancel_i & credit & (outstanding < MAX_OUTSTANDING).
- On inst_req & inst_addr_ok: push pc_i to the pending FIFO and increment outstanding.
- Exception accept: valid_i & adel & !cancel_i & credit & (outstanding == 0).
  - No bus request is made.
  - {pc_i, 0, 1} is written directly into the queue and is visible the next cycle.
  - Because outstanding must be 0, ordering is preserved.
- ready_o = (inst_req & inst_addr_ok) | exception accept.

Response:
- On inst_data_ok: pop the pending FIFO head and decrement outstanding.
  - If discard == 0: enqueue {head pc, inst_rdata, 0}.
  - Otherwise: drop the response and decrement discard.
- The credit rule guarantees queue space, so a response is never lost.
- inst_data_ok with outstanding == 0 is illegal and is asserted against in simulation.

Output:
- valid_o = qcount != 0.
- pc_o, inst_o, exc_o, exccode_o and badvaddr_o are driven from the head entry (registers, no combinational path from the bus).
- Pop when valid_o & ready_i.
- Push and pop in the same cycle keep qcount unchanged.
- The full-queue plus simultaneous-pop case still blocks new issue that cycle, because credit uses the current qcount.

Cancel (cancel_i = 1, single cycle):
- The queue is cleared (qcount = 0); any pop that cycle is ignored.
- No new request or exception accept is made that cycle.
- discard = outstanding - inst_data_ok, where a response arriving in the cancel cycle is itself dropped.
- Issue resumes the next cycle while discard drains.
- Responses are attributed strictly FIFO, so new requests behind discarded ones are enqueued normally.

Mid-operation reset:
- State is cleared at once.
- Bus responses to pre-reset requests are not expected; the bus is reset together with this block.

Test Plan:
1. Streaming:
   - Stimulus: PCs 0x1000, 0x1004, 0x1008, 0x100C; addr_ok every cycle; data_ok one cycle later; ready_i = 1.
   - Required: four valid_o beats in order with correct inst; outstanding never exceeds 2.
2. Backpressure:
   - Stimulus: ready_i = 0 with QUEUE_DEPTH = 4.
   - Required: at most 4 requests are issued in total; inst_req stays 0 once outstanding + qcount = 4; after ready_i = 1, all 4 drain in order with no loss.
3. Misaligned PC:
   - Stimulus: pc_i = 0x2002 while 2 requests are outstanding.
   - Required: ready_o stays 0 until both responses return; the exception is accepted next; the output order is the two instructions, then exc_o = 1, exccode_o = EXC_ADEL, badvaddr_o = 0x2002, inst_o = 0.
4. Cancel with 2 in flight and 1 queued:
   - Stimulus: assert cancel_i.
   - Required: valid_o = 0 the next cycle; the 2 later responses are dropped; a new PC 0x3000 issued after the cancel returns and appears as the first valid_o.
5. Cancel coinciding with inst_data_ok:
   - Stimulus: cancel_i and inst_data_ok in the same cycle, with outstanding = 2.
   - Required: discard = 1; exactly one further response is dropped.
6. Reset:
   - Stimulus: resetn = 0 with a queue holding 3 entries.
   - Required: valid_o, wait_data and inst_req are 0 the next cycle.
